tdm_demux_32ch: RTL and testbench
=================================

// Module: tdm_demux_32ch
// PURPOSE
//  Receive end of the 32-to-1 channel mux path: takes a time-division-multiplexed word stream
//  (one channel word per slot, slot 0 flagged by a sync strobe) and rebuilds the full 32-channel frame.
//  Slots collect in a shadow buffer. Complete frames commit atomically to a parallel output bus.
//  Sits after the serial link and in front of the per-channel consumers.
// PARAMETERS
//  WIDTH   16   bits per channel word
//  NCH     32   channels (slots) per frame; power of two, >=2
//  SLOT_W   5   slot counter width = log2(NCH)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous active-low reset
//  in_valid     in   1            in_data/in_sync valid this cycle
//  in_sync      in   1            marks current word as slot 0
//  in_data      in   WIDTH        channel word for current slot
//  out_bus      out  NCH*WIDTH    last committed frame; channel k at [k*WIDTH +: WIDTH]
//  frame_valid  out  1            1-cycle pulse: out_bus just updated
//  frame_cnt    out  8            committed-frame count, wraps 255->0
//  sync_err     out  1            1-cycle pulse: sync protocol violation
//  slot_cnt     out  SLOT_W       next expected slot (debug)
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_bus=0, shadow=0, frame_valid=0, frame_cnt=0, sync_err=0, slot_cnt=0, state=HUNT.
//  - Cycles with in_valid=0: no state change; in_sync and in_data are ignored.
//  - FSM states HUNT, RECV:
//    HUNT: in_valid&in_sync -> shadow[0]<=in_data, slot_cnt<=1, go RECV. in_valid&!in_sync -> word dropped, no error.
//    RECV, slot_cnt==0: in_valid&in_sync -> store slot 0, slot_cnt<=1.
//      in_valid&!in_sync -> sync_err pulse, word dropped, go HUNT.
//    RECV, 0<slot_cnt<NCH-1: in_valid&!in_sync -> store at slot_cnt, slot_cnt++.
//      in_valid&in_sync -> sync_err pulse; discard partial frame; word becomes slot 0; slot_cnt<=1.
//    RECV, slot_cnt==NCH-1: in_valid&!in_sync -> commit. in_valid&in_sync -> same handling as the early-sync case above.
//  - Commit: out_bus <= shadow with the last word merged in the same edge. No extra latency.
//    frame_valid=1 for exactly that following cycle. frame_cnt++. slot_cnt wraps to 0, stays RECV.
//  - Latency: last word sampled on edge N -> out_bus/frame_valid visible after edge N.
//  - out_bus holds its value between commits. Partial frames never reach out_bus.
//  - Back-to-back frames with no idle cycles are fully supported.
//  - Reset mid-frame discards the partial frame and returns to HUNT.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined:
//    - One extra slot follows slot NCH-1: the XOR of all NCH data words, in_sync=0.
//    - Adds output parity_err (1). Reset 0.
//    - Commit happens only when the parity word matches; frame_valid and frame_cnt move then.
//    - Mismatch: parity_err 1-cycle pulse, out_bus unchanged, slot_cnt<=0, stay RECV.
//    - in_sync on the parity slot is handled like the early-sync case above.
//  TDM_DEMUX_PARITY_EN undefined: no parity slot, no parity_err port; commit after slot NCH-1.
// STRUCTURE
//  - Shared package tdm_pkg: state encoding (ST_HUNT, ST_RECV), default WIDTH/NCH, FRAME_CNT_W=8.
//  - One sub-module tdm_slot_buffer: NCH x WIDTH shadow registers with slot-indexed write enable.
//    Holds the parity accumulator when TDM_DEMUX_PARITY_EN is defined.
//  - Top level holds the FSM, slot counter, commit register and pulse outputs.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles -> out_bus=0, frame_cnt=0, all pulses 0, slot_cnt=0.
//  2. One frame, slot k = 16'h0100+k, sync on slot 0:
//     -> frame_valid 1 cycle after slot 31; out_bus[31*16+:16]=16'h011F; frame_cnt=1.
//  3. Two frames back-to-back (frame 2 words 16'hA000+k) -> two frame_valid pulses 32 cycles apart;
//     out_bus[0+:16]=16'hA000; frame_cnt=2.
//  4. Sync asserted at slot 10 -> sync_err pulse; new frame restarts with that word.
//     32 slots later frame_valid, with out_bus[0+:16]=that word.
//  5. After a commit, next word without sync -> sync_err, state HUNT;
//     following 5 no-sync words dropped silently; out_bus unchanged.
//  6. rst_n low at slot 20, then a full frame -> out_bus holds only the new frame, frame_cnt=1.
//     With TDM_DEMUX_PARITY_EN: corrupted parity word -> parity_err pulse, frame_cnt unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and default sizes for the TDM demux
package tdm_pkg;
  localparam int WIDTH = 16;
  localparam int NCH = 32;
  localparam int SLOT_W = $clog2(NCH);
  localparam int FRAME_CNT_W = 8;
  typedef enum logic {ST_HUNT, ST_RECV} state_t;
endpackage

// File: rtl/tdm_demux_32ch_if.sv
// tdm_demux_32ch_if: TDM word stream, one channel word per valid cycle, sync marks slot 0
interface tdm_demux_32ch_if #(parameter int WIDTH = tdm_pkg::WIDTH);
  logic in_valid;
  logic in_sync;
  logic [WIDTH-1:0] in_data;
  modport master(output in_valid, in_sync, in_data);
  modport slave(input in_valid, in_sync, in_data);
endinterface

// File: rtl/tdm_slot_buffer.sv
// tdm_slot_buffer: NCH x WIDTH shadow frame with slot-indexed write; with TDM_DEMUX_PARITY_EN
// it also keeps the running XOR of the words stored since slot 0
module tdm_slot_buffer
  import tdm_pkg::*;
#(
  parameter int WIDTH = tdm_pkg::WIDTH,
  parameter int NCH = tdm_pkg::NCH,
  parameter int SLOT_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [SLOT_W-1:0]    slot,
  input  logic [WIDTH-1:0]     data,
`ifdef TDM_DEMUX_PARITY_EN
  output logic [WIDTH-1:0]     acc,
`endif
  output logic [NCH*WIDTH-1:0] shadow
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= '0;
    else if (we) shadow[slot*WIDTH +: WIDTH] <= data;
`ifdef TDM_DEMUX_PARITY_EN
  // slot 0 restarts the accumulator, so an aborted partial frame leaves no residue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (we) acc <= (slot == '0) ? data : acc ^ data;
`endif
endmodule

// File: rtl/tdm_demux_32ch.sv
// tdm_demux_32ch: rebuilds NCH-channel frames from a TDM word stream and commits them atomically;
// TDM_DEMUX_PARITY_EN adds a trailing XOR parity slot and the parity_err output
module tdm_demux_32ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = tdm_pkg::WIDTH,
  parameter int NCH = tdm_pkg::NCH,
  parameter int SLOT_W = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tdm_demux_32ch_if.slave        in_if,
  output logic [NCH*WIDTH-1:0]   out_bus,
  output logic                   frame_valid,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   sync_err,
`ifdef TDM_DEMUX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic [SLOT_W-1:0]      slot_cnt
);
  state_t state, state_n;
  logic [SLOT_W-1:0] slot_n;
  logic we, commit, err_n;
  logic [NCH*WIDTH-1:0] shadow, merged;
`ifdef TDM_DEMUX_PARITY_EN
  logic [WIDTH-1:0] acc;
  logic par_ph, par_n, perr_n;
`endif
  tdm_slot_buffer #(.WIDTH(WIDTH), .NCH(NCH), .SLOT_W(SLOT_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .slot(in_if.in_sync ? '0 : slot_cnt),
    .data(in_if.in_data),
`ifdef TDM_DEMUX_PARITY_EN
    .acc(acc),
`endif
    .shadow(shadow)
  );
  always_comb begin
    state_n = state;
    slot_n = slot_cnt;
    we = 1'b0;
    commit = 1'b0;
    err_n = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_n = par_ph;
    perr_n = 1'b0;
`endif
    if (in_if.in_valid) begin
      if (state == ST_HUNT) begin
        we = in_if.in_sync;
        slot_n = in_if.in_sync ? SLOT_W'(1) : slot_cnt;
        state_n = in_if.in_sync ? ST_RECV : ST_HUNT;
      end else if (in_if.in_sync) begin
        we = 1'b1;
        slot_n = SLOT_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
        par_n = 1'b0;
        err_n = par_ph || slot_cnt != '0;
`else
        err_n = slot_cnt != '0;
`endif
`ifdef TDM_DEMUX_PARITY_EN
      end else if (par_ph) begin
        par_n = 1'b0;
        slot_n = '0;
        commit = in_if.in_data == acc;
        perr_n = in_if.in_data != acc;
`endif
      end else if (slot_cnt == '0) begin
        err_n = 1'b1;
        state_n = ST_HUNT;
      end else begin
        we = 1'b1;
        slot_n = slot_cnt + 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
        par_n = slot_cnt == SLOT_W'(NCH - 1);
`else
        commit = slot_cnt == SLOT_W'(NCH - 1);
`endif
      end
    end
  end
  // without parity the last word commits on the edge it arrives, bypassing the shadow
  always_comb begin
    merged = shadow;
`ifndef TDM_DEMUX_PARITY_EN
    merged[(NCH-1)*WIDTH +: WIDTH] = in_if.in_data;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_HUNT;
      slot_cnt <= '0;
      out_bus <= '0;
      frame_valid <= 1'b0;
      frame_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      state <= state_n;
      slot_cnt <= slot_n;
      frame_valid <= commit;
      frame_cnt <= frame_cnt + FRAME_CNT_W'(commit);
      sync_err <= err_n;
      if (commit) out_bus <= merged;
    end
`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par_ph <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_ph <= par_n;
      parity_err <= perr_n;
    end
`endif
endmodule

// File: tb/tb_tdm_demux_32ch.sv
// tb_tdm_demux_32ch: vector table, directed frame sequences and random stream vs. a queue-based frame model
module tb_tdm_demux_32ch;
  import tdm_pkg::*;
  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    bit v;
    bit s;
    word_t d;
    bit efv;
    bit eerr;
    int eslot;
  } vec_t;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR = 1;
  logic parity_err;
`else
  localparam int PAR = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*WIDTH-1:0] out_bus;
  logic frame_valid, sync_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  tdm_demux_32ch_if #(.WIDTH(WIDTH)) bus ();
  tdm_demux_32ch dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_if(bus),
    .out_bus(out_bus),
    .frame_valid(frame_valid),
    .frame_cnt(frame_cnt),
    .sync_err(sync_err),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .slot_cnt(slot_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, last_fv = 0, gap = 0;
  word_t part[$];
  word_t m_bus[NCH];
  bit hunting;
  logic [FRAME_CNT_W-1:0] m_cnt;
  bit m_fv, m_err, m_perr;
  task automatic chk(input string name, input logic [NCH*WIDTH-1:0] act, input logic [NCH*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [NCH*WIDTH-1:0] flat();
    logic [NCH*WIDTH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*WIDTH +: WIDTH] = m_bus[k];
    return r;
  endfunction
  function automatic word_t xor_all();
    word_t x = '0;
    foreach (part[i]) x ^= part[i];
    return x;
  endfunction
  task automatic model_reset();
    part.delete();
    foreach (m_bus[k]) m_bus[k] = '0;
    hunting = 1;
    m_cnt = '0;
    m_fv = 0;
    m_err = 0;
    m_perr = 0;
  endtask
  task automatic model_commit();
    for (int k = 0; k < NCH; k++) m_bus[k] = part[k];
    m_cnt++;
    m_fv = 1;
    part.delete();
  endtask
  task automatic model(input bit v, input bit s, input word_t d);
    m_fv = 0;
    m_err = 0;
    m_perr = 0;
    if (!v) return;
    if (hunting) begin
      if (s) begin
        part = '{d};
        hunting = 0;
      end
    end else if (part.size() == NCH) begin
      if (s) begin
        m_err = 1;
        part = '{d};
      end else if (xor_all() == d) model_commit();
      else begin
        m_perr = 1;
        part.delete();
      end
    end else if (part.size() == 0) begin
      if (s) part = '{d};
      else begin
        m_err = 1;
        hunting = 1;
      end
    end else if (s) begin
      m_err = 1;
      part = '{d};
    end else begin
      part.push_back(d);
      if (part.size() == NCH && PAR == 0) model_commit();
    end
  endtask
  task automatic compare_all();
    chk("frame_valid", frame_valid, m_fv);
    chk("sync_err", sync_err, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("slot_cnt", slot_cnt, hunting ? 0 : part.size() % NCH);
    chk("out_bus", out_bus, flat());
`ifdef TDM_DEMUX_PARITY_EN
    chk("parity_err", parity_err, m_perr);
`endif
  endtask
  task automatic step(input bit v, input bit s, input word_t d);
    bus.in_valid = v;
    bus.in_sync = s;
    bus.in_data = d;
    @(posedge clk);
    model(v, s, d);
    #1;
    cyc++;
    if (frame_valid) begin
      gap = cyc - last_fv;
      last_fv = cyc;
    end
    compare_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask
  task automatic send_frame(input word_t w[NCH], input int from);
    word_t x = '0;
    for (int i = 0; i < NCH; i++) x ^= w[i];
    for (int i = from; i < NCH; i++) step(1, i == 0, w[i]);
    if (PAR != 0) step(1, 0, x);
  endtask
  vec_t tbl[7];
  word_t w[NCH];
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync = 1'b0;
    bus.in_data = '0;
    tbl[0] = '{0, 1, 16'h9999, 0, 0, 0};
    tbl[1] = '{1, 0, 16'h1111, 0, 0, 0};
    tbl[2] = '{1, 1, 16'hAAAA, 0, 0, 1};
    tbl[3] = '{0, 1, 16'h5555, 0, 0, 1};
    tbl[4] = '{1, 0, 16'hBBBB, 0, 0, 2};
    tbl[5] = '{1, 1, 16'hCCCC, 0, 1, 1};
    tbl[6] = '{1, 0, 16'hDDDD, 0, 0, 2};
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("vec%0d_fv", i), frame_valid, tbl[i].efv);
      chk($sformatf("vec%0d_err", i), sync_err, tbl[i].eerr);
      chk($sformatf("vec%0d_slot", i), slot_cnt, tbl[i].eslot);
    end
    do_reset();
    for (int k = 0; k < NCH; k++) w[k] = 16'h0100 + 16'(k);
    send_frame(w, 0);
    chk("t2_fv", frame_valid, 1);
    chk("t2_slot31", out_bus[31*16 +: 16], 16'h011F);
    chk("t2_cnt", frame_cnt, 1);
    step(0, 0, 0);
    chk("t2_fv_drop", frame_valid, 0);
    do_reset();
    send_frame(w, 0);
    for (int k = 0; k < NCH; k++) w[k] = 16'hA000 + 16'(k);
    send_frame(w, 0);
    chk("t3_gap", gap, NCH + PAR);
    chk("t3_slot0", out_bus[15:0], 16'hA000);
    chk("t3_cnt", frame_cnt, 2);
    do_reset();
    for (int k = 0; k < 10; k++) step(1, k == 0, 16'h4000 + 16'(k));
    step(1, 1, 16'hBEEF);
    chk("t4_err", sync_err, 1);
    w[0] = 16'hBEEF;
    for (int k = 1; k < NCH; k++) w[k] = 16'h5000 + 16'(k);
    send_frame(w, 1);
    chk("t4_fv", frame_valid, 1);
    chk("t4_slot0", out_bus[15:0], 16'hBEEF);
    step(1, 0, 16'h1234);
    chk("t5_err", sync_err, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, word_t'($urandom));
      chk("t5_quiet", sync_err, 0);
    end
    chk("t5_hold", out_bus[15:0], 16'hBEEF);
    do_reset();
    for (int k = 0; k < 20; k++) step(1, k == 0, 16'h6000 + 16'(k));
    do_reset();
    for (int k = 0; k < NCH; k++) w[k] = 16'h7000 + 16'(k);
    send_frame(w, 0);
    chk("t6_cnt", frame_cnt, 1);
    chk("t6_slot0", out_bus[15:0], 16'h7000);
    chk("t6_slot31", out_bus[31*16 +: 16], 16'h701F);
`ifdef TDM_DEMUX_PARITY_EN
    begin
      word_t x = '0;
      for (int k = 0; k < NCH; k++) begin
        step(1, k == 0, 16'h3000 + 16'(k));
        x ^= 16'h3000 + 16'(k);
      end
      step(1, 0, x ^ 16'h0001);
      chk("t6_perr", parity_err, 1);
      chk("t6_perr_cnt", frame_cnt, 1);
    end
`endif
    do_reset();
    begin
      int pos = 0;
      word_t px = '0;
      for (int n = 0; n < 4000; n++) begin
        bit v = $urandom_range(0, 9) != 0;
        bit s = (pos == 0) ^ ($urandom_range(0, 49) == 0);
        word_t d = word_t'($urandom);
        if (pos == NCH) d = ($urandom_range(0, 9) == 0) ? d : px;
        else if (pos == 0) px = d;
        else px ^= d;
        step(v, s, d);
        if (v) pos = (pos + 1) % (NCH + PAR);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
